// File: rtl/mem_controller.sv
// Main-memory emulator between a cache and a synchronous word RAM.
// Requests wait LATENCY cycles, touch the RAM once, then pulse ready for one cycle.
module mem_controller #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned LATENCY  = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] cache2mem_addr,
  input  logic [DATA_W-1:0] cache2mem_data,
  input  logic              cache2mem_MemWrite,
  input  logic              cache2mem_MemRead,
  output logic [DATA_W-1:0] mem2cache_data,
  output logic              mem2cache_ready,
  output logic              mem_busy,
  output logic              mem_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned HI_LSB = OFFSET_W + RAM_AW;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_accept;
  logic                w_oor;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_op_wr;
  logic [DATA_W-1:0]   r_rdata;
  logic [RAM_AW-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_we;
  logic                r_ready;
  logic                r_err;
  logic                r_busy;

  // Any address bit above the RAM window marks the request out of range.
  assign w_oor = |(r_addr >> HI_LSB);

  // Next-state and wait-counter logic.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cache2mem_MemRead || cache2mem_MemWrite) begin
          w_next     = WAIT;
          w_cnt_next = CNT_W'(LATENCY - 1);
          w_accept   = 1'b1;
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_next = ACCESS;
        else             w_cnt_next = r_cnt - CNT_W'(1);
      end
      ACCESS:  w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_op_wr     <= 1'b0;
      r_rdata     <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_we        <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= cache2mem_addr;
        r_data  <= cache2mem_data;
        r_op_wr <= cache2mem_MemWrite;
      end
      // RAM address/data are loaded on entry to ACCESS and held afterwards.
      if (w_next == ACCESS) begin
        r_ram_addr  <= r_addr[OFFSET_W +: RAM_AW];
        r_ram_wdata <= r_data;
      end
      r_we <= (w_next == ACCESS) && r_op_wr && !w_oor;
      if ((r_state == CAPTURE) && !r_op_wr) begin
        r_rdata <= w_oor ? '0 : ram_rdata;
      end
      r_ready <= (w_next == RESP);
      r_err   <= (w_next == RESP) && w_oor;
      r_busy  <= (w_next != IDLE);
    end
  end

  assign mem2cache_data  = r_rdata;
  assign mem2cache_ready = r_ready;
  assign mem_err         = r_err;
  assign mem_busy        = r_busy;
  assign ram_addr        = r_ram_addr;
  assign ram_wdata       = r_ram_wdata;
  // Reset must kill a write even while ACCESS is already underway.
  assign ram_we          = r_we & ~iRST;

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller with a behavioural synchronous RAM
// and a scoreboard of expected responses.
module tb_mem_controller;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] cache2mem_addr;
  logic [31:0] cache2mem_data;
  logic        cache2mem_MemWrite;
  logic        cache2mem_MemRead;
  logic [31:0] mem2cache_data;
  logic        mem2cache_ready;
  logic        mem_busy;
  logic        mem_err;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } we_rec_t;

  exp_t        sb_q[$];
  we_rec_t     we_log[$];
  logic [31:0] ram   [0:1023];
  logic [31:0] model [0:1023];
  logic [31:0] exp_out;
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_controller #(
    .ADDR_W(32), .DATA_W(32), .OFFSET_W(2), .RAM_AW(10), .LATENCY(4)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .cache2mem_addr(cache2mem_addr), .cache2mem_data(cache2mem_data),
    .cache2mem_MemWrite(cache2mem_MemWrite), .cache2mem_MemRead(cache2mem_MemRead),
    .mem2cache_data(mem2cache_data), .mem2cache_ready(mem2cache_ready),
    .mem_busy(mem_busy), .mem_err(mem_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every ready pulse is matched against the scoreboard head.
  always @(negedge iCLK) begin
    if (ram_we) we_log.push_back('{a: ram_addr, d: ram_wdata});
    if (mem2cache_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_ready", 32'(mem2cache_ready), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_data", mem2cache_data, e.data);
        check("resp_err", 32'(mem_err), 32'(e.err));
      end
    end else if (mem_err === 1'b1) begin
      check("err_without_ready", 32'(mem_err), 32'd0);
    end
  end

  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input string tag);
    logic       oor;
    logic [9:0] idx;
    int         n;
    int         busy_n;
    logic       got;
    oor = |addr[31:12];
    idx = addr[11:2];
    if (wr) begin
      if (!oor) model[idx] = data;
    end else begin
      exp_out = oor ? 32'd0 : model[idx];
    end
    sb_q.push_back('{data: exp_out, err: oor});
    we_log.delete();
    @(negedge iCLK);
    cache2mem_addr     = addr;
    cache2mem_data     = data;
    cache2mem_MemRead  = rd;
    cache2mem_MemWrite = wr;
    @(posedge iCLK);
    #1;
    cache2mem_MemRead  = 1'b0;
    cache2mem_MemWrite = 1'b0;
    cache2mem_addr     = 32'hFFFF_FFFC;
    cache2mem_data     = 32'h0BAD_0BAD;
    n = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge iCLK);
      n++;
      if (mem_busy) busy_n++;
      if (mem2cache_ready) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'(got), 32'd1);
      sb_q.delete();
    end
    check({tag, "_latency"}, 32'(n), 32'd7);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd7);
    @(negedge iCLK);
    check({tag, "_ready_after"}, 32'(mem2cache_ready), 32'd0);
    check({tag, "_busy_after"}, 32'(mem_busy), 32'd0);
    if (wr && !oor) begin
      check({tag, "_we_count"}, 32'(we_log.size()), 32'd1);
      if (we_log.size() > 0) begin
        check({tag, "_we_addr"}, 32'(we_log[0].a), 32'(idx));
        check({tag, "_we_data"}, we_log[0].d, data);
      end
    end else begin
      check({tag, "_we_count"}, 32'(we_log.size()), 32'd0);
    end
  endtask

  initial begin
    int r1, r2;
    logic b8, b9;
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = 32'd0;
      model[i] = 32'd0;
    end
    ram[4]   = 32'hDEAD_BEEF;  model[4] = 32'hDEAD_BEEF;
    ram[8]   = 32'hCAFE_F00D;  model[8] = 32'hCAFE_F00D;
    exp_out  = 32'd0;
    iRST = 1'b1;
    cache2mem_addr = '0; cache2mem_data = '0;
    cache2mem_MemRead = 1'b0; cache2mem_MemWrite = 1'b0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_data", mem2cache_data, 32'd0);
    check("rst_ready", 32'(mem2cache_ready), 32'd0);
    check("rst_busy", 32'(mem_busy), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    iRST = 1'b0;

    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd10");
    run_txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, "rd13_offset");
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, "wr40");
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, "rd40");
    run_txn(1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, "both08");
    run_txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, "rd08");
    run_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, "rd1000_oor");
    run_txn(1'b0, 1'b1, 32'h8000_0FFC, 32'h7777_7777, "wr_oor");
    run_txn(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, "rd_top");

    // Reset during WAIT of a read.
    we_log.delete();
    @(negedge iCLK);
    cache2mem_addr = 32'h10; cache2mem_MemRead = 1'b1;
    @(posedge iCLK); #1 cache2mem_MemRead = 1'b0;
    @(posedge iCLK); #1 iRST = 1'b1;
    @(posedge iCLK); #1 iRST = 1'b0;
    exp_out = 32'd0;
    @(negedge iCLK);
    check("rstwait_busy", 32'(mem_busy), 32'd0);
    check("rstwait_ready", 32'(mem2cache_ready), 32'd0);
    check("rstwait_data", mem2cache_data, 32'd0);

    // Reset raised inside ACCESS of a write.
    @(negedge iCLK);
    cache2mem_addr = 32'h80; cache2mem_data = 32'h1111_1111; cache2mem_MemWrite = 1'b1;
    @(posedge iCLK); #1 cache2mem_MemWrite = 1'b0;
    repeat (4) @(posedge iCLK);
    #1 iRST = 1'b1;
    @(negedge iCLK);
    check("rstacc_in_access", 32'(ram_addr), 32'd32);
    check("rstacc_we_forced", 32'(ram_we), 32'd0);
    @(posedge iCLK); #1 iRST = 1'b0;
    @(negedge iCLK);
    check("rstacc_busy", 32'(mem_busy), 32'd0);
    check("rstacc_ready", 32'(mem2cache_ready), 32'd0);
    repeat (10) @(negedge iCLK);
    check("rst_no_we", 32'(we_log.size()), 32'd0);
    run_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, "rd80_after_abort");

    // Request held across RESP with the address changed mid-WAIT.
    sb_q.push_back('{data: model[4], err: 1'b0});
    sb_q.push_back('{data: model[8], err: 1'b0});
    r1 = 0; r2 = 0; b8 = 1'b1; b9 = 1'b0;
    @(negedge iCLK);
    cache2mem_addr = 32'h10; cache2mem_MemRead = 1'b1;
    @(posedge iCLK);
    @(posedge iCLK); #1 cache2mem_addr = 32'h20;
    for (int c = 2; c <= 20; c++) begin
      @(negedge iCLK);
      if (mem2cache_ready) begin
        if (r1 == 0) r1 = c;
        else if (r2 == 0) r2 = c;
      end
      if (c == 8) b8 = mem_busy;
      if (c == 9) begin
        b9 = mem_busy;
        cache2mem_MemRead = 1'b0;
      end
    end
    check("hold_first_ready", 32'(r1), 32'd7);
    check("hold_idle_gap", 32'(b8), 32'd0);
    check("hold_reaccept", 32'(b9), 32'd1);
    check("hold_second_ready", 32'(r2), 32'd15);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
